// File: rtl/psram_bus_responder.sv
// Block-RAM backed stand-in for the PSRAM controller user bus.
// Mimics controller busy timing (1x/2x latency) so bus initiators run unchanged without PSRAM pins.
module psram_bus_responder #(
    parameter int unsigned LATENCY     = 3,
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned INIT_CYCLES = 100,
    parameter int unsigned DOUBLE_MODE = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        read,
    input  logic        write,
    input  logic        byte_write,
    input  logic [21:0] addr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        busy,
    output logic        protocol_err
);

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned DEPTH   = 2 ** ADDR_BITS;
    localparam int unsigned NW_1X   = 3 + LATENCY;
    localparam int unsigned NW_2X   = 3 + 2 * LATENCY;
    localparam int unsigned NR_1X   = 8 + LATENCY;
    localparam int unsigned NR_2X   = 8 + 2 * LATENCY;
    localparam int unsigned CNT_MAX = (INIT_CYCLES > NR_2X) ? INIT_CYCLES : NR_2X;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic        FORCE_2X  = (DOUBLE_MODE == 1);
    localparam logic        RANDOM_2X = (DOUBLE_MODE >= 2);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_WAIT_W = 2'd2,
        ST_WAIT_R = 2'd3
    } state_t;

    // Command captured at accept; payload stays stable for the whole busy window.
    typedef struct packed {
        logic [ADDR_BITS-1:0] idx;
        logic                 hi_lane;
        logic                 byte_wr;
        logic [DATA_W-1:0]    data;
    } cmd_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_d;
    logic [DATA_W-1:0]  dout_d;
    logic               err_d;
    logic [15:0]        lfsr_q, lfsr_d, lfsr_next;
    cmd_t               cmd_q, cmd_d;
    logic               use_2x;
    logic               we_lo, we_hi;
    logic [DATA_W-1:0]  ram_q;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic               unused_addr_hi;

    assign unused_addr_hi = ^addr[21:ADDR_BITS+1];

    // Fibonacci LFSR for x^16 + x^14 + x^13 + x^11 + 1.
    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign use_2x    = FORCE_2X | (RANDOM_2X & lfsr_q[0]);

    // State register and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_INIT;
            cnt_q        <= CNT_W'(INIT_CYCLES - 1);
            busy         <= 1'b1;
            dout         <= '0;
            protocol_err <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            cmd_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy         <= busy_d;
            dout         <= dout_d;
            protocol_err <= err_d;
            lfsr_q       <= lfsr_d;
            cmd_q        <= cmd_d;
        end
    end

    // Next-state, counter and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy;
        dout_d  = dout;
        err_d   = protocol_err;
        lfsr_d  = lfsr_q;
        cmd_d   = cmd_q;
        we_lo   = 1'b0;
        we_hi   = 1'b0;

        if ((state_q != ST_IDLE) && (read || write)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_INIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (read || write) begin
                    // Simultaneous read and write: the write wins, the read is dropped.
                    if (read && write) begin
                        err_d = 1'b1;
                    end
                    cmd_d.idx     = addr[ADDR_BITS:1];
                    cmd_d.hi_lane = addr[0];
                    cmd_d.byte_wr = byte_write;
                    cmd_d.data    = din;
                    lfsr_d        = lfsr_next;
                    busy_d        = 1'b1;
                    if (write) begin
                        state_d = ST_WAIT_W;
                        cnt_d   = use_2x ? CNT_W'(NW_2X - 1) : CNT_W'(NW_1X - 1);
                    end else begin
                        state_d = ST_WAIT_R;
                        cnt_d   = use_2x ? CNT_W'(NR_2X - 1) : CNT_W'(NR_1X - 1);
                    end
                end
            end
            ST_WAIT_W: begin
                if (cnt_q == '0) begin
                    we_lo   = !cmd_q.byte_wr || !cmd_q.hi_lane;
                    we_hi   = !cmd_q.byte_wr || cmd_q.hi_lane;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT_R: begin
                if (cnt_q == '0) begin
                    dout_d  = ram_q;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Backing store: per-lane write on the last write cycle, read address follows the latched index.
    always_ff @(posedge clk) begin
        if (we_lo) begin
            mem[cmd_q.idx][7:0] <= cmd_q.data[7:0];
        end
        if (we_hi) begin
            mem[cmd_q.idx][15:8] <= cmd_q.data[15:8];
        end
        ram_q <= mem[cmd_q.idx];
    end

endmodule
